// File: rtl/byte_word_packer.sv
// Packs a valid/ready byte stream into 32-bit words (first byte in [31:24]), padding short final words.
// Latency: word is presented 1 cycle after its completing byte is accepted; in_ready = !out_valid || out_ready.
module byte_word_packer #(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] out_word,
    output logic [3:0]  out_keep,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] word_count
);

    logic [1:0]  cnt_q,  cnt_d;
    logic [23:0] acc_q,  acc_d;
    logic [31:0] word_q, word_d;
    logic [3:0]  keep_q, keep_d;
    logic        last_q, last_d;
    logic        vld_q,  vld_d;
    logic [15:0] wcnt_q, wcnt_d;

    logic in_fire;
    logic out_fire;

    // The output slot can take a new word whenever it is empty or draining this cycle.
    assign in_ready = !vld_q || out_ready;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = vld_q && out_ready;

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        word_d = word_q;
        keep_d = keep_q;
        last_d = last_q;
        vld_d  = vld_q;
        wcnt_d = wcnt_q;

        if (out_fire) begin
            vld_d  = 1'b0;
            wcnt_d = wcnt_q + 16'd1;
        end

        if (in_fire) begin
            if (cnt_q == 2'd3 || in_last) begin
                cnt_d  = 2'd0;
                vld_d  = 1'b1;
                last_d = in_last;
                case (cnt_q)
                    2'd0: begin
                        word_d = {in_byte, PAD_BYTE, PAD_BYTE, PAD_BYTE};
                        keep_d = 4'b1000;
                    end
                    2'd1: begin
                        word_d = {acc_q[23:16], in_byte, PAD_BYTE, PAD_BYTE};
                        keep_d = 4'b1100;
                    end
                    2'd2: begin
                        word_d = {acc_q[23:8], in_byte, PAD_BYTE};
                        keep_d = 4'b1110;
                    end
                    default: begin
                        word_d = {acc_q, in_byte};
                        keep_d = 4'b1111;
                    end
                endcase
            end else begin
                cnt_d = cnt_q + 2'd1;
                case (cnt_q)
                    2'd0:    acc_d[23:16] = in_byte;
                    2'd1:    acc_d[15:8]  = in_byte;
                    default: acc_d[7:0]   = in_byte;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= 2'd0;
            acc_q  <= 24'd0;
            word_q <= 32'd0;
            keep_q <= 4'd0;
            last_q <= 1'b0;
            vld_q  <= 1'b0;
            wcnt_q <= 16'd0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            word_q <= word_d;
            keep_q <= keep_d;
            last_q <= last_d;
            vld_q  <= vld_d;
            wcnt_q <= wcnt_d;
        end
    end

    assign out_word   = word_q;
    assign out_keep   = keep_q;
    assign out_last   = last_q;
    assign out_valid  = vld_q;
    assign word_count = wcnt_q;

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed and randomized checks of byte_word_packer against a byte-queue scoreboard.
module tb_byte_word_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_last;
    logic        out_ready;

    logic        in_ready,  in_ready_e;
    logic [31:0] out_word,  out_word_e;
    logic [3:0]  out_keep,  out_keep_e;
    logic        out_last,  out_last_e;
    logic        out_valid, out_valid_e;
    logic [15:0] word_count, word_count_e;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    byte_word_packer dut (
        .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .out_word(out_word),
        .out_keep(out_keep), .out_last(out_last), .out_valid(out_valid),
        .out_ready(out_ready), .word_count(word_count)
    );

    byte_word_packer #(.PAD_BYTE(8'hEE)) dut_ee (
        .clk(clk), .rst_n(rst_n), .in_byte(in_byte), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready_e), .out_word(out_word_e),
        .out_keep(out_keep_e), .out_last(out_last_e), .out_valid(out_valid_e),
        .out_ready(out_ready), .word_count(word_count_e)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until accepted, bounded by a cycle budget.
    task automatic send(input logic [7:0] b, input logic l);
        int waited;
        in_byte  = b;
        in_last  = l;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        chk("send_accept_timeout", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    logic [7:0]  bq[$];
    logic        lq[$];
    int          sent;
    int          nwords;
    int          cycles;
    int          nreal;
    logic [7:0]  eb;
    logic        el;
    logic        held;
    logic [31:0] held_word;
    logic [3:0]  held_keep;
    logic        held_last;

    initial begin
        // Reset with random inputs driven
        rst_n     = 1'b0;
        in_byte   = 8'($urandom);
        in_valid  = 1'($urandom);
        in_last   = 1'($urandom);
        out_ready = 1'($urandom);
        #2;
        chk("rst_word",  out_word, 32'd0);
        chk("rst_keep",  {28'd0, out_keep}, 32'd0);
        chk("rst_last",  {31'd0, out_last}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_wcnt",  {16'd0, word_count}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        tick();
        tick();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b1;
        tick();

        // Full word
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        send(8'h56, 1'b0);
        send(8'h78, 1'b0);
        chk("full_valid", {31'd0, out_valid}, 32'd1);
        chk("full_word",  out_word, 32'h12345678);
        chk("full_keep",  {28'd0, out_keep}, 32'hF);
        chk("full_last",  {31'd0, out_last}, 32'd0);
        chk("full_wcnt_pre", {16'd0, word_count}, 32'd0);
        tick();
        chk("full_wcnt", {16'd0, word_count}, 32'd1);
        chk("full_drained", {31'd0, out_valid}, 32'd0);

        // Short word, default and EE padding
        send(8'hAB, 1'b0);
        send(8'hCD, 1'b1);
        chk("short_word", out_word, 32'hABCD0000);
        chk("short_keep", {28'd0, out_keep}, 32'hC);
        chk("short_last", {31'd0, out_last}, 32'd1);
        chk("short_word_ee", out_word_e, 32'hABCDEEEE);
        chk("short_keep_ee", {28'd0, out_keep_e}, 32'hC);
        tick();
        chk("short_wcnt", {16'd0, word_count}, 32'd2);

        // Single-byte packet
        send(8'h5A, 1'b1);
        chk("one_word", out_word, 32'h5A000000);
        chk("one_keep", {28'd0, out_keep}, 32'h8);
        chk("one_word_ee", out_word_e, 32'h5AEEEEEE);
        tick();

        // Backpressure
        out_ready = 1'b0;
        send(8'h12, 1'b0);
        send(8'h34, 1'b0);
        send(8'h56, 1'b0);
        send(8'h78, 1'b0);
        in_byte  = 8'h9A;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
            chk("bp_valid",     {31'd0, out_valid}, 32'd1);
            chk("bp_word_hold", out_word, 32'h12345678);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_recover", {31'd0, in_ready}, 32'd1);
        tick();
        chk("bp_wcnt_mid", {16'd0, word_count}, 32'd4);
        in_valid = 1'b0;
        send(8'hBC, 1'b0);
        send(8'hDE, 1'b0);
        send(8'hF0, 1'b0);
        chk("bp_word2", out_word, 32'h9ABCDEF0);
        chk("bp_keep2", {28'd0, out_keep}, 32'hF);
        chk("bp_valid2", {31'd0, out_valid}, 32'd1);
        tick();
        chk("bp_wcnt", {16'd0, word_count}, 32'd5);

        // Mid-word asynchronous reset
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_wcnt",  {16'd0, word_count}, 32'd0);
        chk("mrst_word",  out_word, 32'd0);
        #1 rst_n = 1'b1;
        tick();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        chk("mrst_word2", out_word, 32'h11223344);
        chk("mrst_keep2", {28'd0, out_keep}, 32'hF);
        tick();
        chk("mrst_wcnt2", {16'd0, word_count}, 32'd1);
        chk("mrst_idle",  {31'd0, out_valid}, 32'd0);

        // Random stream against the byte-queue scoreboard
        sent   = 0;
        nwords = 0;
        cycles = 0;
        held   = 1'b0;
        while ((sent < 1000 || out_valid) && cycles < 20000) begin
            in_valid  = (sent < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
            in_byte   = 8'($urandom);
            in_last   = ($urandom_range(0, 4) == 0);
            if (sent == 999 && in_valid) in_last = 1'b1;
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            chk("rnd_in_ready", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
            if (held) begin
                chk("rnd_hold_word", out_word, held_word);
                chk("rnd_hold_keep", {28'd0, out_keep}, {28'd0, held_keep});
                chk("rnd_hold_last", {31'd0, out_last}, {31'd0, held_last});
            end
            held      = out_valid && !out_ready;
            held_word = out_word;
            held_keep = out_keep;
            held_last = out_last;
            if (in_valid && in_ready) begin
                bq.push_back(in_byte);
                lq.push_back(in_last);
                sent++;
            end
            if (out_valid && out_ready) begin
                nwords++;
                case (out_keep)
                    4'b1000: nreal = 1;
                    4'b1100: nreal = 2;
                    4'b1110: nreal = 3;
                    4'b1111: nreal = 4;
                    default: nreal = 0;
                endcase
                chk("rnd_keep_shape", {31'd0, nreal != 0}, 32'd1);
                if (nreal < 4)
                    chk("rnd_short_is_last", {31'd0, out_last}, 32'd1);
                for (int i = 0; i < 4; i++) begin
                    if (i < nreal) begin
                        chk("rnd_underflow", {31'd0, bq.size() != 0}, 32'd1);
                        if (bq.size() != 0) begin
                            eb = bq.pop_front();
                            el = lq.pop_front();
                            chk("rnd_byte", {24'd0, out_word[31-8*i -: 8]}, {24'd0, eb});
                            if (i == nreal - 1)
                                chk("rnd_last", {31'd0, out_last}, {31'd0, el});
                            else
                                chk("rnd_early_last", {31'd0, el}, 32'd0);
                        end
                    end else begin
                        chk("rnd_pad", {24'd0, out_word[31-8*i -: 8]}, 32'd0);
                    end
                end
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        chk("rnd_timeout", {31'd0, cycles < 20000}, 32'd1);
        chk("rnd_all_sent", sent, 32'd1000);
        chk("rnd_drained", bq.size(), 32'd0);
        chk("rnd_wcnt", {16'd0, word_count}, {16'd0, 16'(1 + nwords)});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
